// File: rtl/dte20_ebus_port.sv
// EBUS register port of one DTE20 front-end interface: CONO/CONI/DATAO/DATAI decode,
// doorbells, PI assignment and 36-bit word exchange. Optional loopback under DTE_LOOPBACK_EN.
module dte20_ebus_port #(
  parameter logic [0:6] CS_SELECT = 7'o40
) (
  input  logic        clk30,
  input  logic        CROBAR,
  input  logic [0:6]  ebus_cs,
  input  logic [0:2]  ebus_func,
  input  logic        ebus_demand,
  input  logic [0:35] ebus_data_in,
  output logic        ebus_driving,
  output logic [0:35] ebus_data_out,
  output logic        ebus_xfer,
  output logic [1:7]  pi_req,
  output logic [0:35] to_fe_data,
  output logic        to_fe_doorbell,
  input  logic        fe_ring,
  input  logic        fe_clear_doorbell,
  input  logic [0:35] fe_data,
  input  logic        fe_load
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [0:2] FN_CONO  = 3'd0;
  localparam logic [0:2] FN_CONI  = 3'd1;
  localparam logic [0:2] FN_DATAO = 3'd2;
  localparam logic [0:2] FN_DATAI = 3'd3;

  state_t      state, state_nxt;

  logic        to10db, to10db_nxt;
  logic        to11db, to11db_nxt;
  logic        pi0en, pi0en_nxt;
  logic [0:2]  pia, pia_nxt;
  logic [0:35] datao_reg, datao_nxt;
  logic [0:35] datai_reg, datai_nxt;
  logic        loop;

  logic        xfer_nxt;
  logic        driving_nxt;
  logic [0:35] data_out_nxt;
  logic [1:7]  pi_req_nxt;

  logic        accept;
  logic        do_cono, do_coni, do_datao, do_datai;
  logic [0:35] coni_word;
  logic [0:35] datai_word;

  // Func codes 4-7 have the top bit set and are never answered.
  assign accept   = (state == IDLE) && ebus_demand && (ebus_cs == CS_SELECT) && !ebus_func[0];
  assign do_cono  = accept && (ebus_func == FN_CONO);
  assign do_coni  = accept && (ebus_func == FN_CONI);
  assign do_datao = accept && (ebus_func == FN_DATAO);
  assign do_datai = accept && (ebus_func == FN_DATAI);

`ifdef DTE_LOOPBACK_EN
  logic loop_nxt;

  always_comb begin
    loop_nxt = loop;
    if (do_cono && ebus_data_in[31]) loop_nxt = ebus_data_in[25];
  end

  always_ff @(posedge clk30 or posedge CROBAR) begin
    if (CROBAR) loop <= 1'b0;
    else        loop <= loop_nxt;
  end
`else
  assign loop = 1'b0;
`endif

  always_comb begin
    coni_word        = '0;
    coni_word[22]    = to11db;
    coni_word[23]    = to10db;
    coni_word[25]    = loop;
    coni_word[32]    = pi0en;
    coni_word[33:35] = pia;
  end

  assign datai_word = loop ? datao_reg : datai_reg;

  function automatic logic [1:7] pi_decode(input logic active, input logic [0:2] level);
    logic [1:7] req;
    req = '0;
    for (int n = 1; n <= 7; n++) req[n] = active && (level == 3'(n));
    return req;
  endfunction

  // Register-file next values. A front-end set beats a same-cycle EBUS clear and vice versa.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    to10db_nxt = to10db;
    to11db_nxt = to11db;
    pi0en_nxt  = pi0en;
    pia_nxt    = pia;
    datao_nxt  = datao_reg;
    datai_nxt  = datai_reg;

    if (do_cono && ebus_data_in[23]) to10db_nxt = 1'b0;
    if (fe_ring)                     to10db_nxt = 1'b1;

    if (fe_clear_doorbell)           to11db_nxt = 1'b0;
    if (do_cono && ebus_data_in[22]) to11db_nxt = 1'b1;

    if (do_cono && ebus_data_in[31]) begin
      pi0en_nxt = ebus_data_in[32];
      pia_nxt   = ebus_data_in[33:35];
    end

    if (do_datao) datao_nxt = ebus_data_in;
    if (fe_load)  datai_nxt = fe_data;

    pi_req_nxt = pi_decode(to10db_nxt, pia_nxt);
  end

  always_comb begin
    state_nxt    = state;
    xfer_nxt     = 1'b0;
    driving_nxt  = ebus_driving;
    data_out_nxt = ebus_data_out;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ACK;
          xfer_nxt  = 1'b1;
          if (do_coni) begin
            driving_nxt  = 1'b1;
            data_out_nxt = coni_word;
          end else if (do_datai) begin
            driving_nxt  = 1'b1;
            data_out_nxt = datai_word;
          end
        end
      end
      ACK: state_nxt = HOLD;
      HOLD: begin
        if (!ebus_demand) begin
          state_nxt    = IDLE;
          driving_nxt  = 1'b0;
          data_out_nxt = '0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        driving_nxt  = 1'b0;
        data_out_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk30 or posedge CROBAR) begin
    if (CROBAR) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the data words are reset as well, so no stale word survives CROBAR.
  always_ff @(posedge clk30 or posedge CROBAR) begin
    if (CROBAR) begin
      to10db        <= 1'b0;
      to11db        <= 1'b0;
      pi0en         <= 1'b0;
      pia           <= '0;
      datao_reg     <= '0;
      datai_reg     <= '0;
      ebus_xfer     <= 1'b0;
      ebus_driving  <= 1'b0;
      ebus_data_out <= '0;
      pi_req        <= '0;
    end else begin
      to10db        <= to10db_nxt;
      to11db        <= to11db_nxt;
      pi0en         <= pi0en_nxt;
      pia           <= pia_nxt;
      datao_reg     <= datao_nxt;
      datai_reg     <= datai_nxt;
      ebus_xfer     <= xfer_nxt;
      ebus_driving  <= driving_nxt;
      ebus_data_out <= data_out_nxt;
      pi_req        <= pi_req_nxt;
    end
  end

  assign to_fe_doorbell = to11db;
  assign to_fe_data     = datao_reg;

endmodule

// File: tb/tb_dte20_ebus_port.sv
// Bench for dte20_ebus_port: directed steps then random EBUS/front-end traffic against a
// register-level model of the DTE20 port. Honours DTE_LOOPBACK_EN when defined.
module tb_dte20_ebus_port;

  logic        clk30 = 1'b0;
  logic        CROBAR;
  logic [0:6]  ebus_cs;
  logic [0:2]  ebus_func;
  logic        ebus_demand;
  logic [0:35] ebus_data_in;
  logic        ebus_driving;
  logic [0:35] ebus_data_out;
  logic        ebus_xfer;
  logic [1:7]  pi_req;
  logic [0:35] to_fe_data;
  logic        to_fe_doorbell;
  logic        fe_ring;
  logic        fe_clear_doorbell;
  logic [0:35] fe_data;
  logic        fe_load;

  int total = 0;
  int bad   = 0;

  bit          m_to10db, m_to11db, m_pi0en, m_loop;
  bit [2:0]    m_pia;
  logic [35:0] m_datao, m_datai;

  always #5 clk30 = ~clk30;

  dte20_ebus_port dut (
    .clk30(clk30), .CROBAR(CROBAR), .ebus_cs(ebus_cs), .ebus_func(ebus_func),
    .ebus_demand(ebus_demand), .ebus_data_in(ebus_data_in), .ebus_driving(ebus_driving),
    .ebus_data_out(ebus_data_out), .ebus_xfer(ebus_xfer), .pi_req(pi_req),
    .to_fe_data(to_fe_data), .to_fe_doorbell(to_fe_doorbell), .fe_ring(fe_ring),
    .fe_clear_doorbell(fe_clear_doorbell), .fe_data(fe_data), .fe_load(fe_load)
  );

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
    end
  endtask

  // Bit b of a PDP-10 word (bit 0 is the most significant of 36).
  function automatic bit wbit(input logic [35:0] w, input int b);
    return w[35 - b];
  endfunction

  function automatic logic [35:0] model_coni();
    logic [35:0] v;
    v = '0;
    v = v | (36'(m_to11db) << (35 - 22));
    v = v | (36'(m_to10db) << (35 - 23));
    v = v | (36'(m_loop)   << (35 - 25));
    v = v | (36'(m_pi0en)  << (35 - 32));
    v = v | 36'(m_pia);
    return v;
  endfunction

  function automatic logic [6:0] model_pi();
    if (m_to10db && m_pia != 0) return 7'b1000000 >> (m_pia - 3'd1);
    return 7'b0;
  endfunction

  task automatic model_reset();
    m_to10db = 0; m_to11db = 0; m_pi0en = 0; m_loop = 0; m_pia = 0;
    m_datao = '0; m_datai = '0;
  endtask

  task automatic model_update(input bit acc, input logic [2:0] func, input logic [35:0] w,
                              input bit ring, input bit clr, input bit load,
                              input logic [35:0] fdata);
    bit cono_set11;
    cono_set11 = acc && func == 0 && wbit(w, 22);
    if (acc && func == 0) begin
      if (wbit(w, 22)) m_to11db = 1;
      if (wbit(w, 23)) m_to10db = 0;
      if (wbit(w, 31)) begin
        m_pi0en = wbit(w, 32);
        m_pia   = w[2:0];
`ifdef DTE_LOOPBACK_EN
        m_loop  = wbit(w, 25);
`endif
      end
    end
    if (ring) m_to10db = 1;
    if (clr && !cono_set11) m_to11db = 0;
    if (acc && func == 2) m_datao = w;
    if (load) m_datai = fdata;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pi_req"}, 36'(pi_req), 36'(model_pi()));
    check({tag, ".doorbell"}, 36'(to_fe_doorbell), 36'(m_to11db));
    check({tag, ".to_fe_data"}, to_fe_data, m_datao);
  endtask

  // One EBUS cycle with optional coincident front-end pulses; hold_extra keeps demand up longer.
  task automatic op(input logic [2:0] func, input logic [6:0] cs, input logic [35:0] w,
                    input int hold_extra, input bit ring, input bit clr, input bit load,
                    input logic [35:0] fdata, input string tag);
    bit          acc, rd;
    int          seen;
    logic [35:0] exp_rd;
    acc    = (cs == 7'o40) && (func < 3'd4);
    rd     = acc && (func == 3'd1 || func == 3'd3);
    exp_rd = (func == 3'd1) ? model_coni() : (m_loop ? m_datao : m_datai);
    @(negedge clk30);
    ebus_func = func; ebus_cs = cs; ebus_data_in = w; ebus_demand = 1'b1;
    fe_ring = ring; fe_clear_doorbell = clr; fe_load = load; fe_data = fdata;
    @(negedge clk30);
    fe_ring = 1'b0; fe_clear_doorbell = 1'b0; fe_load = 1'b0;
    if (acc) begin
      check({tag, ".xfer"}, 36'(ebus_xfer), 36'd1);
      check({tag, ".driving"}, 36'(ebus_driving), 36'(rd));
      check({tag, ".data_out"}, ebus_data_out, rd ? exp_rd : 36'd0);
      @(negedge clk30);
      check({tag, ".xfer_one"}, 36'(ebus_xfer), 36'd0);
      check({tag, ".hold_drv"}, 36'(ebus_driving), 36'(rd));
      for (int i = 0; i < hold_extra; i++) begin
        @(negedge clk30);
        check({tag, ".held_drv"}, 36'(ebus_driving), 36'(rd));
        check({tag, ".held_data"}, ebus_data_out, rd ? exp_rd : 36'd0);
      end
      ebus_demand = 1'b0;
      @(negedge clk30);
      check({tag, ".drop_drv"}, 36'(ebus_driving), 36'd0);
      check({tag, ".drop_data"}, ebus_data_out, 36'd0);
    end else begin
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (ebus_xfer || ebus_driving) seen++;
        @(negedge clk30);
      end
      check({tag, ".no_resp"}, 36'(seen), 36'd0);
      ebus_demand = 1'b0;
      @(negedge clk30);
    end
    model_update(acc, func, w, ring, clr, load, fdata);
    check_state(tag);
  endtask

  task automatic fe_pulse(input bit ring, input bit clr, input bit load,
                          input logic [35:0] fdata, input string tag);
    @(negedge clk30);
    fe_ring = ring; fe_clear_doorbell = clr; fe_load = load; fe_data = fdata;
    @(negedge clk30);
    fe_ring = 1'b0; fe_clear_doorbell = 1'b0; fe_load = 1'b0;
    model_update(0, 3'd7, '0, ring, clr, load, fdata);
    check_state(tag);
  endtask

  localparam logic [35:0] B22 = 36'd1 << (35 - 22);
  localparam logic [35:0] B23 = 36'd1 << (35 - 23);
  localparam logic [35:0] B25 = 36'd1 << (35 - 25);
  localparam logic [35:0] B31 = 36'd1 << (35 - 31);

  initial begin
    logic [2:0]  rf;
    logic [6:0]  rcs;
    logic [35:0] rw, rfd;

    CROBAR = 1'b1; ebus_cs = '0; ebus_func = '0; ebus_demand = 1'b0; ebus_data_in = '0;
    fe_ring = 1'b0; fe_clear_doorbell = 1'b0; fe_data = '0; fe_load = 1'b0;
    model_reset();
    repeat (3) @(negedge clk30);
    check("rst.driving", 36'(ebus_driving), 36'd0);
    check("rst.xfer", 36'(ebus_xfer), 36'd0);
    check("rst.data_out", ebus_data_out, 36'd0);
    check_state("rst");
    CROBAR = 1'b0;

    // PI assignment level 5 and doorbell, then a front-end ring raises level 5.
    op(3'd0, 7'o40, B31 | B22 | 36'd5, 0, 0, 0, 0, '0, "cono_pia");
    fe_pulse(1, 0, 0, '0, "ring");
    check("ring.pi5", 36'(pi_req), 36'(7'b0000100));
    op(3'd1, 7'o40, '0, 1, 0, 0, 0, '0, "coni1");

    // CROBAR in the middle of a DATAI with driving up.
    @(negedge clk30);
    ebus_func = 3'd3; ebus_cs = 7'o40; ebus_demand = 1'b1;
    @(negedge clk30);
    check("mid.driving", 36'(ebus_driving), 36'd1);
    #2 CROBAR = 1'b1;
    #1;
    check("crobar.driving", 36'(ebus_driving), 36'd0);
    check("crobar.xfer", 36'(ebus_xfer), 36'd0);
    check("crobar.pi_req", 36'(pi_req), 36'd0);
    check("crobar.doorbell", 36'(to_fe_doorbell), 36'd0);
    @(negedge clk30);
    ebus_demand = 1'b0;
    @(negedge clk30);
    CROBAR = 1'b0;
    model_reset();
    op(3'd1, 7'o40, '0, 0, 0, 0, 0, '0, "post_rst_coni");

    // DATAO, front-end load, DATAI with demand held longer.
    op(3'd2, 7'o40, 36'o123456701234, 0, 0, 0, 0, '0, "datao");
    check("datao.to_fe", to_fe_data, 36'o123456701234);
    fe_pulse(0, 0, 1, 36'o777000111222, "fe_load");
    op(3'd3, 7'o40, '0, 3, 0, 0, 0, '0, "datai");
    // Coincident fe_load returns the old word, next DATAI sees the new one.
    op(3'd3, 7'o40, '0, 0, 0, 0, 1, 36'o111222333444, "datai_race");
    op(3'd3, 7'o40, '0, 0, 0, 0, 0, '0, "datai_new");

    // Select decode.
    op(3'd3, 7'o41, '0, 0, 0, 0, 0, '0, "bad_cs");
    op(3'd4, 7'o40, '0, 0, 0, 0, 0, '0, "bad_func");

    // Doorbell races.
    op(3'd0, 7'o40, B31 | 36'd2, 0, 0, 0, 0, '0, "pia2");
    op(3'd0, 7'o40, B23, 0, 1, 0, 0, '0, "race10");
    check("race10.pi2", 36'(pi_req), 36'(7'b0100000));
    op(3'd0, 7'o40, B22, 0, 0, 1, 0, '0, "race11");
    check("race11.db", 36'(to_fe_doorbell), 36'd1);
    op(3'd0, 7'o40, B23, 0, 0, 0, 0, '0, "clr10");
    fe_pulse(0, 1, 0, '0, "clr11");

    // Loopback: CONO b25 with b31, DATAO 5, DATAI and CONI.
    op(3'd0, 7'o40, B31 | B25 | 36'd1, 0, 0, 0, 0, '0, "loop_on");
    op(3'd2, 7'o40, 36'o5, 0, 0, 0, 0, '0, "loop_datao");
    op(3'd3, 7'o40, '0, 0, 0, 0, 0, '0, "loop_datai");
    op(3'd1, 7'o40, '0, 0, 0, 0, 0, '0, "loop_coni");
    op(3'd0, 7'o40, B31, 0, 0, 0, 0, '0, "loop_off");

    for (int n = 0; n < 200; n++) begin
      rf  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rcs = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'o40;
      rw  = {4'($urandom), 32'($urandom)};
      rfd = {4'($urandom), 32'($urandom)};
      if ($urandom_range(0, 4) == 0)
        fe_pulse(1'($urandom), 1'($urandom), 1'($urandom), rfd, "rnd_fe");
      else
        op(rf, rcs, rw, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), rfd, "rnd_op");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dte20_ebus_port.md
Name: dte20_ebus_port

Overview:
- EBUS-side register port of one DTE20 front-end interface: decodes EBUS CONO/CONI/DATAO/DATAI cycles addressed to its controller select.
- Holds doorbell and PI-assignment state, and exchanges 36-bit words with the front-end.
- Raises a PI request on its assigned level when the front-end rings the host.
- Sits beside the EBOX on the muxed EBUS; its driving/data pair feeds the top-level EBUS data mux.

Parameters:
- CS_SELECT, 7'o40, EBUS controller-select value this DTE answers (device code 200 shifted right by 2).

Ports:
- clk30  input  1  system clock; all state on rising edge.
- CROBAR  input  1  reset, asynchronous, active-high.
- ebus_cs  input  7 [0:6]  controller select.
- ebus_func  input  3 [0:2]  function: 0 CONO, 1 CONI, 2 DATAO, 3 DATAI, 4-7 ignored.
- ebus_demand  input  1  EBOX demand, level held until ebus_xfer seen.
- ebus_data_in  input  36 [0:35]  EBUS data from EBOX (CONO/DATAO).
- ebus_driving  output  1  this port drives EBUS data (mux select).
- ebus_data_out  output  36 [0:35]  data when driving, else 0.
- ebus_xfer  output  1  one-cycle transfer acknowledge.
- pi_req  output  7 [1:7]  one-hot PI request.
- to_fe_data  output  36 [0:35]  last DATAO word.
- to_fe_doorbell  output  1  TO11DB flag to front-end.
- fe_ring  input  1  front-end pulse: set TO10DB.
- fe_clear_doorbell  input  1  front-end pulse: clear TO11DB.
- fe_data  input  36 [0:35]  front-end word.
- fe_load  input  1  capture fe_data into DATAI register.

Behaviour:
- Reset (async, CROBAR=1) clears all state, regardless of any cycle in progress:
  - all outputs 0;
  - TO10DB, TO11DB, PIA[0:2], PI0EN, DATAO reg and DATAI reg all 0;
  - FSM to IDLE.
- FSM states IDLE, ACK, HOLD. All outputs registered.
- IDLE -> ACK: when ebus_demand=1, ebus_cs==CS_SELECT and func is 0-3; action performed on that edge.
- Non-matching cs or func 4-7: stay IDLE, no response.
- ACK: ebus_xfer=1 for exactly one cycle, i.e. the cycle after demand is sampled. Next state HOLD.
- HOLD: ebus_xfer=0. Return to IDLE on the first cycle with ebus_demand=0. No new cycle is accepted until demand has dropped.
- CONI/DATAI: ebus_driving=1 and ebus_data_out valid in ACK and throughout HOLD; both drop together on return to IDLE.
  - ebus_data_out is the value latched on entry to ACK.
- CONO write bits:
  - b22=1: set TO11DB.
  - b23=1: clear TO10DB.
  - b31=1: load PI0EN from b32 and PIA from b33:35.
  - All other bits ignored.
- CONI read format: b22 TO11DB, b23 TO10DB, b32 PI0EN, b33:35 PIA; all other bits 0.
- DATAO: DATAO reg <= ebus_data_in; to_fe_data mirrors DATAO reg.
- DATAI: returns DATAI reg, which is loaded from fe_data on fe_load.
  - fe_load coincident with DATAI acceptance: the old value is returned; the new value is captured.
- to_fe_doorbell = TO11DB.
- pi_req[n]=1 iff TO10DB=1 and PIA==n (1-7). PIA=0 gives no request. PI0EN is status only.
- Simultaneous events:
  - fe_ring and CONO clear TO10DB in the same cycle: set wins.
  - CONO set TO11DB and fe_clear_doorbell in the same cycle: set wins.

Optional Feature:
- Macro DTE_LOOPBACK_EN.
- Defined:
  - CONO b31 also loads a LOOP flag from b25; CONI b25 = LOOP.
  - While LOOP=1, DATAI returns the DATAO reg instead of the DATAI reg.
- Undefined: b25 ignored on CONO and reads 0 on CONI; DATAI always returns the DATAI reg.

Test Plan:
- Reset: assert CROBAR mid-DATAI (driving=1) -> ebus_driving, ebus_xfer, pi_req, to_fe_doorbell all 0 immediately; FSM IDLE after release.
- CONO: data with b31=1, b33:35=3'd5, cs=7'o40; then fe_ring pulse -> xfer one cycle after demand; pi_req=7'b0000100 (level 5); CONI reads b23=1, b33:35=5.
- DATAO then DATAI: DATAO 36'o123456701234; fe_load with fe_data=36'o777000111222; DATAI -> to_fe_data=36'o123456701234; DATAI returns 36'o777000111222 with driving held until demand drops.
- Select decode: demand with cs=7'o41 or func=4 -> no xfer, no driving for 10 cycles.
- Doorbell race: CONO b23=1 in the same cycle as fe_ring -> TO10DB remains 1. CONO b22=1 with fe_clear_doorbell -> to_fe_doorbell=1.
- Loopback (DTE_LOOPBACK_EN): CONO b31=1, b25=1; DATAO 36'o5; DATAI -> returns 36'o5. Without the macro -> returns DATAI reg, CONI b25=0.
